// File: rtl/fe_carry_reduce.sv
// ---------------------------------------------------------------------------
// fe_carry_reduce
//
// Sequential carry-propagation stage for GF(2^255-19) field elements held in
// 10-limb radix-2^25.5 form (ref10 layout). Ten wide signed accumulators from
// the multiply/square stage are latched, then the standard 12-step carry chain
// is applied one step per clock. Each step rounds the source limb to nearest
// by forming c = (h_src + 2^(s-1)) >>> s, removes c << s from the source and
// adds c (or 19*c on the wrap from limb 9 to limb 0) to the destination.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_limbs carries an element
//   in_ready   : block is idle and will accept an element
//   in_limbs   : 10 packed signed limbs, limb i at [i*IN_W +: IN_W]
//   out_valid  : out_limbs holds a reduced element
//   out_ready  : consumer takes the element
//   out_limbs  : 10 packed signed reduced limbs, limb i at [i*OUT_W +: OUT_W]
//   busy       : carry chain in progress
//
// OUT_W must be at least 27 so the widest reduced limb (|h| <= 2^25) keeps
// its sign when truncated.
// ---------------------------------------------------------------------------
module fe_carry_reduce #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [10*IN_W-1:0]    in_limbs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*OUT_W-1:0]   out_limbs,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CARRY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] LAST_STEP = 4'd11;
    localparam logic [3:0] WRAP_STEP = 4'd10;   // the 9 -> 0 step

    // Rounding offsets 2^(s-1) for s = 26 (even source) and s = 25 (odd).
    localparam logic signed [IN_W-1:0] RND_EVEN = IN_W'(1) << 25;
    localparam logic signed [IN_W-1:0] RND_ODD  = IN_W'(1) << 24;

    logic [1:0]              r_state;
    logic [3:0]              r_k;
    logic signed [IN_W-1:0]  r_h   [10];
    logic signed [OUT_W-1:0] r_out [10];

    logic                    w_load;
    logic                    w_step;
    logic                    w_last;
    logic [3:0]              w_src;
    logic [3:0]              w_dst;
    logic                    w_src_odd;
    logic                    w_wrap;
    logic signed [IN_W-1:0]  w_h_src;
    logic signed [IN_W-1:0]  w_rounded;
    logic signed [IN_W-1:0]  w_carry;
    logic signed [IN_W-1:0]  w_carry_shl;
    logic signed [IN_W-1:0]  w_dst_add;
    logic signed [IN_W-1:0]  w_h_next [10];

    // -----------------------------------------------------------------------
    // Step schedule: source / destination limb for each of the 12 steps.
    // The two interleaved chains (0..4 and 4..9) meet at 4->5 and 9->0.
    // -----------------------------------------------------------------------
    always_comb begin
        w_src = 4'd0;
        w_dst = 4'd1;
        case (r_k)
            4'd0:    begin w_src = 4'd0; w_dst = 4'd1; end
            4'd1:    begin w_src = 4'd4; w_dst = 4'd5; end
            4'd2:    begin w_src = 4'd1; w_dst = 4'd2; end
            4'd3:    begin w_src = 4'd5; w_dst = 4'd6; end
            4'd4:    begin w_src = 4'd2; w_dst = 4'd3; end
            4'd5:    begin w_src = 4'd6; w_dst = 4'd7; end
            4'd6:    begin w_src = 4'd3; w_dst = 4'd4; end
            4'd7:    begin w_src = 4'd7; w_dst = 4'd8; end
            4'd8:    begin w_src = 4'd4; w_dst = 4'd5; end
            4'd9:    begin w_src = 4'd8; w_dst = 4'd9; end
            4'd10:   begin w_src = 4'd9; w_dst = 4'd0; end
            4'd11:   begin w_src = 4'd0; w_dst = 4'd1; end
            default: begin w_src = 4'd0; w_dst = 4'd1; end
        endcase
    end

    assign w_load    = (r_state == ST_IDLE) && in_valid;
    assign w_step    = (r_state == ST_CARRY);
    assign w_last    = w_step && (r_k == LAST_STEP);
    assign w_src_odd = w_src[0];
    assign w_wrap    = (r_k == WRAP_STEP);

    // -----------------------------------------------------------------------
    // Single carry datapath shared by all steps.
    // -----------------------------------------------------------------------
    assign w_h_src     = r_h[w_src];
    assign w_rounded   = w_h_src + (w_src_odd ? RND_ODD : RND_EVEN);
    assign w_carry     = w_src_odd ? (w_rounded >>> 25) : (w_rounded >>> 26);
    assign w_carry_shl = w_src_odd ? (w_carry <<< 25) : (w_carry <<< 26);
    // 2^255 == 19 (mod p): the carry out of limb 9 re-enters limb 0 times 19.
    assign w_dst_add   = w_wrap ? ((w_carry <<< 4) + (w_carry <<< 1) + w_carry)
                                : w_carry;

    // -----------------------------------------------------------------------
    // Per-limb state: next value, working register and output register.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_limb
            assign w_h_next[gi] = (w_src == 4'(gi)) ? (r_h[gi] - w_carry_shl) :
                                  (w_dst == 4'(gi)) ? (r_h[gi] + w_dst_add)   :
                                                      r_h[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_h[gi] <= '0;
                end else if (w_load) begin
                    r_h[gi] <= in_limbs[gi*IN_W +: IN_W];
                end else if (w_step) begin
                    r_h[gi] <= w_h_next[gi];
                end
            end

            // Captured from the post-step value so the last step is included.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out[gi] <= '0;
                end else if (w_last) begin
                    r_out[gi] <= w_h_next[gi][OUT_W-1:0];
                end
            end

            assign out_limbs[gi*OUT_W +: OUT_W] = r_out[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM and step counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_CARRY;
                        r_k     <= 4'd0;
                    end
                end
                ST_CARRY: begin
                    if (r_k == LAST_STEP) begin
                        r_state <= ST_DONE;
                        r_k     <= 4'd0;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_k     <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_CARRY);

endmodule

// File: tb/tb_fe_carry_reduce.sv
// ---------------------------------------------------------------------------
// tb_fe_carry_reduce
//
// Directed-vector bench for fe_carry_reduce. Expected limbs for every vector
// are worked out by hand from the round-to-nearest carry chain.
// ---------------------------------------------------------------------------
module tb_fe_carry_reduce;

    localparam int IN_W  = 64;
    localparam int OUT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [10*IN_W-1:0]   in_limbs;
    logic                 out_valid;
    logic                 out_ready;
    logic [10*OUT_W-1:0]  out_limbs;
    logic                 busy;

    int     n_checks = 0;
    int     n_errors = 0;
    int     txn      = 0;
    longint vec_in  [10];
    longint vec_exp [10];

    always #5 clk = ~clk;

    fe_carry_reduce #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_limbs  (in_limbs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_limbs (out_limbs),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint out_limb(input int i);
        logic signed [OUT_W-1:0] v;
        v = out_limbs[i*OUT_W +: OUT_W];
        return longint'(v);
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < 10; i++) begin
            vec_in[i]  = 0;
            vec_exp[i] = 0;
        end
    endtask

    // Present vec_in for one cycle while the block is idle.
    task automatic send_vec();
        @(negedge clk);
        check_val("in_ready_before_send", longint'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            in_limbs[i*IN_W +: IN_W] = vec_in[i];
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("busy_after_accept", longint'(busy), 1);
    endtask

    // Count edges from acceptance to out_valid, bounded.
    task automatic wait_out();
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            check_val("out_valid_timeout", 0, 1);
        end else begin
            check_val("latency", longint'(lat), 12);
        end
        check_val("busy_in_done", longint'(busy), 0);
    endtask

    task automatic check_out(input string name);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("%s_limb%0d", name, i), out_limb(i), vec_exp[i]);
        end
        txn++;
        $display("txn %0d %s: out0=%0d out1=%0d out4=%0d out9=%0d",
                 txn, name, out_limb(0), out_limb(1), out_limb(4), out_limb(9));
    endtask

    // With out_ready high the handshake takes the next edge.
    task automatic finish_handshake(input string name);
        @(posedge clk);
        #1;
        check_val({name, "_in_ready_after_hs"}, longint'(in_ready), 1);
        check_val({name, "_out_valid_after_hs"}, longint'(out_valid), 0);
    endtask

    task automatic run_vec(input string name);
        send_vec();
        wait_out();
        check_out(name);
        finish_handshake(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_limbs  = '0;
        out_ready = 1'b1;
        clear_vec();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready",  longint'(in_ready),  1);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_busy",      longint'(busy),      0);
        check_val("rst_out_zero",  (out_limbs == '0) ? 0 : 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All zero.
        clear_vec();
        run_vec("zero");

        // Limb0 = 2^25: c = 1, limb0 -> -2^25, limb1 -> 1.
        clear_vec();
        vec_in[0]  = 64'sd1 <<< 25;
        vec_exp[0] = -(64'sd1 <<< 25);
        vec_exp[1] = 1;
        run_vec("l0_2p25");

        // Limb9 = 2^25: c = (2^25 + 2^24) >>> 25 = 1, limb9 -> 0, limb0 -> 19.
        clear_vec();
        vec_in[9]  = 64'sd1 <<< 25;
        vec_exp[0] = 19;
        vec_exp[9] = 0;
        run_vec("l9_wrap");

        // Limb0 = -1 stays; limb3 = 2^40 carries 2^15 into limb4 (2^117 both sides).
        clear_vec();
        vec_in[0]  = -1;
        vec_in[3]  = 64'sd1 <<< 40;
        vec_exp[0] = -1;
        vec_exp[4] = 32768;
        run_vec("l3_2p40");

        // Limb8 = 2^50, limb9 = -2^40: 8->9 carries 2^24, 9->0 carries -32767.
        clear_vec();
        vec_in[8]  = 64'sd1 <<< 50;
        vec_in[9]  = -(64'sd1 <<< 40);
        vec_exp[0] = -622573;
        vec_exp[9] = -16777216;
        run_vec("l8l9_mix");

        // Backpressure: hold out_ready low for 5 cycles with in_valid pulses.
        clear_vec();
        vec_in[0]  = 64'sd1 <<< 25;
        vec_exp[0] = -(64'sd1 <<< 25);
        vec_exp[1] = 1;
        out_ready  = 1'b0;
        send_vec();
        wait_out();
        check_out("bp");
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_limbs = '0;
            in_limbs[IN_W-1:0] = 64'd12345;
            @(posedge clk);
            #1;
            check_val($sformatf("bp_in_ready_c%0d", cyc),  longint'(in_ready),  0);
            check_val($sformatf("bp_out_valid_c%0d", cyc), longint'(out_valid), 1);
            check_val($sformatf("bp_out0_c%0d", cyc), out_limb(0), -(64'sd1 <<< 25));
            check_val($sformatf("bp_out1_c%0d", cyc), out_limb(1), 1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_handshake("bp");
        @(posedge clk);
        #1;
        check_val("bp_idle_in_ready",  longint'(in_ready),  1);
        check_val("bp_idle_out_valid", longint'(out_valid), 0);
        txn++;
        $display("txn %0d bp_release: in_ready=%0d out_valid=%0d", txn, in_ready, out_valid);

        // Reset in the middle of the chain (after 6 steps).
        clear_vec();
        vec_in[9] = 64'sd1 <<< 25;
        send_vec();
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_busy",      longint'(busy),      0);
        check_val("midrst_out_valid", longint'(out_valid), 0);
        check_val("midrst_in_ready",  longint'(in_ready),  1);
        check_val("midrst_out_zero",  (out_limbs == '0) ? 0 : 1, 0);
        txn++;
        $display("txn %0d mid_reset: busy=%0d out_valid=%0d in_ready=%0d",
                 txn, busy, out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh element after the reset.
        clear_vec();
        vec_in[8]  = 64'sd1 <<< 50;
        vec_in[9]  = -(64'sd1 <<< 40);
        vec_exp[0] = -622573;
        vec_exp[9] = -16777216;
        run_vec("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
